// File: rtl/pin_scan_sequencer_pkg.sv
// pin_scan_pkg: FSM state encoding, ASCII constants and message length for pin_scan_sequencer.
package pin_scan_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_DRIVE = 3'd1;
  localparam state_t S_EMIT  = 3'd2;
  localparam state_t S_HOLD  = 3'd3;
  localparam state_t S_NEXT  = 3'd4;
  localparam logic [7:0] CHAR_P  = 8'h50;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] LF      = 8'h0A;
  localparam int MSG_LEN = 6;
endpackage

// File: rtl/pin_scan_sequencer_bin_to_bcd3.sv
// bin_to_bcd3: sequential repeated-subtraction binary to 3-digit BCD; at most 19 cycles for inputs up to 999.
module bin_to_bcd3 #(
  parameter int IDX_W = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [IDX_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [3:0]       hund_o,
  output logic [3:0]       tens_o,
  output logic [3:0]       ones_o
);
  // at least 10 bits so the 100/10 constants always fit
  localparam int RW = (IDX_W > 10) ? IDX_W : 10;
  logic [RW-1:0] rem_q;
  logic [3:0]    hund_q, tens_q;
  logic          busy_q, done_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      hund_q <= '0;
      tens_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= RW'(bin_i);
      hund_q <= '0;
      tens_q <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      if (rem_q >= RW'(100)) begin
        rem_q  <= rem_q - RW'(100);
        hund_q <= hund_q + 4'd1;
      end else if (rem_q >= RW'(10)) begin
        rem_q  <= rem_q - RW'(10);
        tens_q <= tens_q + 4'd1;
      end else begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hund_o = hund_q;
  assign tens_o = tens_q;
  assign ones_o = rem_q[3:0];
endmodule

// File: rtl/pin_scan_sequencer.sv
// pin_scan_sequencer: walks an active level across NUM_PINS pins and sends "Pddd\r\n" per pin over valid/ready.
// Define PIN_SCAN_WALK_ZERO_EN for walking-zero pins (idle high); default is walking-one.
module pin_scan_sequencer
  import pin_scan_pkg::*;
#(
  parameter int          NUM_PINS    = 64,
  parameter logic [31:0] HOLD_CYCLES = 32'd2500000,
  parameter int          IDX_W       = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                tx_ready_i,
  output logic                tx_valid_o,
  output logic [7:0]          tx_byte_o,
  output logic [NUM_PINS-1:0] pins_o,
  output logic [IDX_W-1:0]    pin_idx_o,
  output logic                scan_active_o
);
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [31:0]        hold_q, hold_d;
  logic               bcd_busy, bcd_done;
  logic [3:0]         hund, tens, ones;
  logic [7:0]         byte_sel;
  logic [NUM_PINS-1:0] hot;
  logic               xfer;

  bin_to_bcd3 #(.IDX_W(IDX_W)) u_bcd (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(state_q == S_DRIVE),
    .bin_i  (idx_q),
    .busy_o (bcd_busy),
    .done_o (bcd_done),
    .hund_o (hund),
    .tens_o (tens),
    .ones_o (ones)
  );

  // 'P' needs no digits, so it goes out while the converter is still working
  assign tx_valid_o = (state_q == S_EMIT) && (cnt_q == 3'd0 || (bcd_done && !bcd_busy));
  assign xfer       = tx_valid_o && tx_ready_i;
  assign byte_sel   = (cnt_q == 3'd0) ? CHAR_P :
                      (cnt_q == 3'd1) ? ASCII_0 + {4'h0, hund} :
                      (cnt_q == 3'd2) ? ASCII_0 + {4'h0, tens} :
                      (cnt_q == 3'd3) ? ASCII_0 + {4'h0, ones} :
                      (cnt_q == 3'd4) ? CR : LF;
  assign tx_byte_o  = tx_valid_o ? byte_sel : 8'h00;
  assign hot        = (state_q == S_EMIT || state_q == S_HOLD) ? (NUM_PINS'(1) << idx_q) : '0;
`ifdef PIN_SCAN_WALK_ZERO_EN
  assign pins_o = ~hot;
`else
  assign pins_o = hot;
`endif
  assign pin_idx_o     = idx_q;
  assign scan_active_o = state_q != S_IDLE;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: if (enable_i) begin
        state_d = S_DRIVE;
        idx_d   = '0;
      end
      S_DRIVE: begin
        state_d = S_EMIT;
        cnt_d   = '0;
      end
      S_EMIT: if (xfer) begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(MSG_LEN - 1)) begin
          state_d = S_HOLD;
          hold_d  = '0;
        end
      end
      S_HOLD: begin
        state_d = (hold_q == HOLD_CYCLES - 32'd1) ? S_NEXT : S_HOLD;
        hold_d  = (hold_q == HOLD_CYCLES - 32'd1) ? 32'd0 : hold_q + 32'd1;
      end
      S_NEXT: begin
        state_d = enable_i ? S_DRIVE : S_IDLE;
        idx_d   = !enable_i ? idx_q : (idx_q == IDX_W'(NUM_PINS - 1)) ? '0 : idx_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end
endmodule

// File: tb/tb_pin_scan_sequencer.sv
// tb_pin_scan_sequencer: directed checks of pin_scan_sequencer with 4-pin and 130-pin instances.
module tb_pin_scan_sequencer;
`ifdef PIN_SCAN_WALK_ZERO_EN
  localparam bit WZ = 1'b1;
`else
  localparam bit WZ = 1'b0;
`endif
  logic         clk = 1'b0;
  logic         rst, en, rdy;
  logic         rst_b, en_b;
  logic         vld, vld_b, act, act_b;
  logic [7:0]   byt, byt_b;
  logic [3:0]   pins;
  logic [129:0] pins_b;
  logic [9:0]   idx, idx_b;
  logic [7:0]   q4[$];
  logic [7:0]   qb[$];
  logic         pend;
  logic [7:0]   pend_b;
  int           total = 0;
  int           bad = 0;
  logic [7:0]   bt[6]   = '{8'h50, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
  logic [7:0]   m001[6] = '{8'h50, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A};
  logic [7:0]   m002[6] = '{8'h50, 8'h30, 8'h30, 8'h32, 8'h0D, 8'h0A};
  logic [7:0]   m123[6] = '{8'h50, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A};
  logic [7:0]   m129[6] = '{8'h50, 8'h31, 8'h32, 8'h39, 8'h0D, 8'h0A};

  always #5 clk = ~clk;

  pin_scan_sequencer #(.NUM_PINS(4), .HOLD_CYCLES(32'd10), .IDX_W(10)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .tx_ready_i(rdy), .tx_valid_o(vld),
    .tx_byte_o(byt), .pins_o(pins), .pin_idx_o(idx), .scan_active_o(act)
  );
  pin_scan_sequencer #(.NUM_PINS(130), .HOLD_CYCLES(32'd2), .IDX_W(10)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .enable_i(en_b), .tx_ready_i(1'b1), .tx_valid_o(vld_b),
    .tx_byte_o(byt_b), .pins_o(pins_b), .pin_idx_o(idx_b), .scan_active_o(act_b)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ep(input logic [3:0] x);
    return WZ ? ~x : x;
  endfunction

  // transfer log plus a record of any byte left pending under backpressure
  always @(posedge clk) begin
    if (vld && rdy) q4.push_back(byt);
    if (vld_b) qb.push_back(byt_b);
    pend   <= vld && !rdy && !rst;
    pend_b <= byt;
  end
  always @(negedge clk) if (pend && !rst) begin
    chk("hold_valid", vld, 1'b1);
    chk("hold_byte", byt, pend_b);
  end

  initial begin
    rst = 1'b1; en = 1'b0; rdy = 1'b1; rst_b = 1'b1; en_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pins", pins, ep(4'b0000));
    chk("rst_valid", vld, 1'b0);
    chk("rst_byte", byt, 8'h00);
    chk("rst_idx", idx, 10'd0);
    chk("rst_active", act, 1'b0);
    chk("rst_pins_b", pins_b, WZ ? {130{1'b1}} : 130'd0);
    chk("rst_valid_b", vld_b, 1'b0);
    rst = 1'b0; en = 1'b1; rst_b = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("t%0d_valid", k), vld, (k >= 1 && k <= 6) || k == 19);
      chk($sformatf("t%0d_byte", k), byt, (k >= 1 && k <= 6) ? bt[k-1] : (k == 19) ? 8'h50 : 8'h00);
      chk($sformatf("t%0d_pins", k), pins, ep((k >= 1 && k <= 16) ? 4'b0001 : (k == 19) ? 4'b0010 : 4'b0000));
      chk($sformatf("t%0d_active", k), act, 1'b1);
    end
    for (int c = 0; c < 100 && q4.size() < 12; c++) @(negedge clk);
    for (int i = 0; i < 6; i++) chk("msg_p001", q4[6+i], m001[i]);
    // backpressure through pin 2, dropping enable during its message
    for (int c = 0; c < 400 && !(idx == 10'd2 && vld); c++) begin
      @(negedge clk);
      rdy = $urandom_range(0, 9) < 3;
    end
    chk("reach_p002", idx == 10'd2 && vld, 1'b1);
    en = 1'b0;
    for (int c = 0; c < 500 && act; c++) begin
      @(negedge clk);
      rdy = $urandom_range(0, 9) < 3;
    end
    chk("stop_active", act, 1'b0);
    chk("stop_pins", pins, ep(4'b0000));
    chk("stop_idx", idx, 10'd2);
    chk("stop_valid", vld, 1'b0);
    chk("stop_count", q4.size(), 18);
    for (int i = 0; i < 6; i++) chk("msg_p002", q4[12+i], m002[i]);
    rdy = 1'b1; en = 1'b1;
    for (int c = 0; c < 100 && q4.size() < 24; c++) @(negedge clk);
    for (int i = 0; i < 6; i++) chk("restart_p000", q4[18+i], bt[i]);
    // park on pin 1's tens digit, then reset
    for (int c = 0; c < 100 && q4.size() < 26; c++) @(negedge clk);
    rdy = 1'b0;
    chk("tens_valid", vld, 1'b1);
    chk("tens_byte", byt, 8'h30);
    chk("tens_idx", idx, 10'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_valid", vld, 1'b0);
    chk("mrst_pins", pins, ep(4'b0000));
    chk("mrst_active", act, 1'b0);
    rst = 1'b0; rdy = 1'b1; en = 1'b1;
    q4.delete();
    for (int c = 0; c < 100 && q4.size() < 6; c++) @(negedge clk);
    for (int i = 0; i < 6; i++) chk("mrst_p000", q4[i], bt[i]);
    // 130-pin instance: three-digit index and wrap-around
    en_b = 1'b1;
    for (int c = 0; c < 8000 && qb.size() < 786; c++) @(negedge clk);
    chk("b_count", qb.size() >= 786, 1'b1);
    for (int i = 0; i < 6; i++) chk("b_p123", qb[738+i], m123[i]);
    for (int i = 0; i < 6; i++) chk("b_p129", qb[774+i], m129[i]);
    for (int i = 0; i < 6; i++) chk("b_wrap_p000", qb[780+i], bt[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
